// File: rtl/spi_slave_if_pkg.sv
// Shared definitions for the SPI responder: default frame width, FSM state
// encodings and SPI mode encodings with small decode helpers.
package spi_slave_if_pkg;

    localparam int SPI_DATA_W = 8;

    typedef enum logic [1:0] {
        SPI_ST_WAIT_DESEL = 2'd0,
        SPI_ST_IDLE       = 2'd1,
        SPI_ST_SHIFT      = 2'd2
    } spi_state_e;

    typedef enum logic [1:0] {
        SPI_MODE0 = 2'd0,
        SPI_MODE1 = 2'd1,
        SPI_MODE2 = 2'd2,
        SPI_MODE3 = 2'd3
    } spi_mode_e;

    function automatic logic spi_mode_cpol(input spi_mode_e mode);
        return mode[1];
    endfunction

    function automatic logic spi_mode_cpha(input spi_mode_e mode);
        return mode[0];
    endfunction

endpackage

// File: rtl/spi_slave_if_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, with single-cycle rise and
// fall pulses derived from the last stage and one extra history flop.
module spi_slave_if_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_last;

    // Reset loads the idle level so no spurious edge appears after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {STAGES{RST_VAL}};
            r_last <= RST_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_last <= r_sync[STAGES-1];
        end
    end

    assign o_sync = r_sync[STAGES-1];
    assign o_rise = r_sync[STAGES-1] & ~r_last;
    assign o_fall = ~r_sync[STAGES-1] & r_last;

endmodule

// File: rtl/spi_slave_if.sv
// SPI responder (mode 0, MSB first) oversampled in the clk domain, with tx
// holding buffer and rx register. SPI_SLAVE_MODE_SEL_EN adds cpol/cpha inputs.
module spi_slave_if
    import spi_slave_if_pkg::*;
#(
    parameter int                DATA_W      = SPI_DATA_W,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] IDLE_TX     = {DATA_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              scs,
    input  logic              sdi,
`ifdef SPI_SLAVE_MODE_SEL_EN
    input  logic              cpol,
    input  logic              cpha,
`endif
    output logic              sdo,
    output logic              sdo_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ack,
    input  logic              err_clr,
    output logic              overrun,
    output logic              underrun,
    output logic              busy
);

    localparam int                CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};

    logic w_sck_sync, w_sck_rise, w_sck_fall;
    logic w_scs_sync, w_scs_rise, w_scs_fall;
    logic w_sdi_sync, w_sdi_rise, w_sdi_fall;
    logic w_unused;

    spi_state_e r_state, w_next_state;
    logic [SYNC_STAGES:0] r_settle;
    logic w_settled;

    logic w_sample_edge, w_shift_edge, w_frame_cpha, w_start_cpha;
    logic w_start, w_stop, w_sample, w_shift, w_reload, w_tx_load, w_word_end;
    logic [DATA_W-1:0] w_tx_word, w_rx_word;

    logic [DATA_W-1:0] r_tx_buf, r_tx_shift, r_rx_shift, r_rx_data;
    logic              r_tx_ready, r_sdo, r_sdo_oe, r_word_done;
    logic              r_rx_valid, r_overrun, r_underrun;
    logic [CNT_W-1:0]  r_bitcnt;

    spi_slave_if_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk(clk), .rst(rst), .i_async(sck),
        .o_sync(w_sck_sync), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
    );

    spi_slave_if_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_scs (
        .clk(clk), .rst(rst), .i_async(scs),
        .o_sync(w_scs_sync), .o_rise(w_scs_rise), .o_fall(w_scs_fall)
    );

    spi_slave_if_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
        .clk(clk), .rst(rst), .i_async(sdi),
        .o_sync(w_sdi_sync), .o_rise(w_sdi_rise), .o_fall(w_sdi_fall)
    );

    assign w_unused = ^{w_sck_sync, w_sdi_rise, w_sdi_fall};

`ifdef SPI_SLAVE_MODE_SEL_EN
    spi_mode_e r_mode;
    logic      w_lead_edge, w_trail_edge;

    // Mode is captured once per frame at selection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode <= SPI_MODE0;
        end else if (w_start) begin
            r_mode <= spi_mode_e'({cpol, cpha});
        end
    end

    assign w_lead_edge   = spi_mode_cpol(r_mode) ? w_sck_fall : w_sck_rise;
    assign w_trail_edge  = spi_mode_cpol(r_mode) ? w_sck_rise : w_sck_fall;
    assign w_sample_edge = spi_mode_cpha(r_mode) ? w_trail_edge : w_lead_edge;
    assign w_shift_edge  = spi_mode_cpha(r_mode) ? w_lead_edge : w_trail_edge;
    assign w_frame_cpha  = spi_mode_cpha(r_mode);
    assign w_start_cpha  = cpha;
`else
    assign w_sample_edge = w_sck_rise;
    assign w_shift_edge  = w_sck_fall;
    assign w_frame_cpha  = 1'b0;
    assign w_start_cpha  = 1'b0;
`endif

    // Synchronizers hold the reset idle pattern for a while; scs is only trusted once they reflect the pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_settle <= {(SYNC_STAGES + 1){1'b0}};
        end else begin
            r_settle <= {r_settle[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign w_settled = r_settle[SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SPI_ST_WAIT_DESEL;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            SPI_ST_WAIT_DESEL: w_next_state = (w_settled && w_scs_sync) ? SPI_ST_IDLE : SPI_ST_WAIT_DESEL;
            SPI_ST_IDLE:       w_next_state = w_scs_fall ? SPI_ST_SHIFT : SPI_ST_IDLE;
            SPI_ST_SHIFT:      w_next_state = w_scs_rise ? SPI_ST_IDLE : SPI_ST_SHIFT;
            default:           w_next_state = SPI_ST_WAIT_DESEL;
        endcase
    end

    // Deselect takes priority over any sck edge seen in the same cycle.
    always_comb begin
        w_start  = 1'b0;
        w_stop   = 1'b0;
        w_sample = 1'b0;
        w_shift  = 1'b0;
        case (r_state)
            SPI_ST_IDLE: begin
                w_start = w_scs_fall;
            end
            SPI_ST_SHIFT: begin
                w_stop   = w_scs_rise;
                w_sample = w_sample_edge && !w_scs_rise;
                w_shift  = w_shift_edge && !w_scs_rise;
            end
            default: begin
                w_start = 1'b0;
            end
        endcase
    end

    assign w_reload   = w_shift && (r_bitcnt == CNT_ZERO) && r_word_done;
    assign w_tx_load  = w_start || w_reload;
    assign w_word_end = w_sample && (r_bitcnt == LAST_BIT);
    assign w_tx_word  = r_tx_ready ? IDLE_TX : r_tx_buf;
    assign w_rx_word  = {r_rx_shift[DATA_W-2:0], w_sdi_sync};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_buf   <= {DATA_W{1'b0}};
            r_tx_ready <= 1'b1;
        end else if (w_tx_load && !r_tx_ready) begin
            r_tx_ready <= 1'b1;
        end else if (tx_valid && r_tx_ready) begin
            r_tx_buf   <= tx_data;
            r_tx_ready <= 1'b0;
        end
    end

    // With cpha=1 the MSB is only presented on the first leading edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_shift <= {DATA_W{1'b0}};
            r_sdo      <= 1'b0;
        end else if (w_stop) begin
            r_sdo <= 1'b0;
        end else if (w_tx_load) begin
            r_tx_shift <= w_tx_word;
            r_sdo      <= (w_start && w_start_cpha) ? 1'b0 : w_tx_word[DATA_W-1];
        end else if (w_shift && (r_bitcnt != CNT_ZERO)) begin
            r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
            r_sdo      <= r_tx_shift[DATA_W-2];
        end else if (w_shift && w_frame_cpha) begin
            r_sdo <= r_tx_shift[DATA_W-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sdo_oe <= 1'b0;
        end else if (w_start) begin
            r_sdo_oe <= 1'b1;
        end else if (w_stop) begin
            r_sdo_oe <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bitcnt    <= CNT_ZERO;
            r_word_done <= 1'b0;
            r_rx_shift  <= {DATA_W{1'b0}};
        end else if (w_start || w_stop) begin
            r_bitcnt    <= CNT_ZERO;
            r_word_done <= 1'b0;
        end else if (w_sample) begin
            r_rx_shift  <= w_rx_word;
            r_bitcnt    <= w_word_end ? CNT_ZERO : (r_bitcnt + CNT_ONE);
            r_word_done <= w_word_end;
        end else if (w_reload) begin
            r_word_done <= 1'b0;
        end
    end

    // A completing word wins over rx_ack, so an ack in that cycle consumes the old word only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_data  <= {DATA_W{1'b0}};
            r_rx_valid <= 1'b0;
        end else if (w_word_end) begin
            r_rx_data  <= w_rx_word;
            r_rx_valid <= 1'b1;
        end else if (rx_ack) begin
            r_rx_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (w_word_end && r_rx_valid && !rx_ack) begin
                r_overrun <= 1'b1;
            end else if (err_clr) begin
                r_overrun <= 1'b0;
            end
            if (w_tx_load && r_tx_ready) begin
                r_underrun <= 1'b1;
            end else if (err_clr) begin
                r_underrun <= 1'b0;
            end
        end
    end

    assign sdo      = r_sdo;
    assign sdo_oe   = r_sdo_oe;
    assign tx_ready = r_tx_ready;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign overrun  = r_overrun;
    assign underrun = r_underrun;
    assign busy     = (r_state == SPI_ST_SHIFT);

endmodule

// File: tb/tb_spi_slave_if.sv
// Scenario bench for spi_slave_if: bit-banged SPI master, queues of expected
// MISO words and expected received words.
module tb_spi_slave_if;

    logic       clk = 1'b0;
    logic       rst, sck, scs, sdi;
    logic       sdo, sdo_oe;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ack, err_clr;
    logic       overrun, underrun, busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] miso_q[$];
    logic [7:0] rx_q[$];

    always #5 clk = ~clk;

    spi_slave_if #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sck(sck), .scs(scs), .sdi(sdi),
        .sdo(sdo), .sdo_oe(sdo_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
        .err_clr(err_clr), .overrun(overrun), .underrun(underrun), .busy(busy)
    );

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sel();
        scs = 1'b0;
        wait_n(6);
    endtask

    task automatic desel();
        sck = 1'b0;
        scs = 1'b1;
        wait_n(6);
    endtask

    task automatic ack();
        rx_ack = 1'b1;
        wait_n(1);
        rx_ack = 1'b0;
    endtask

    task automatic clr_err();
        err_clr = 1'b1;
        wait_n(1);
        err_clr = 1'b0;
    endtask

    task automatic push_tx(input logic [7:0] v);
        int k;
        k = 0;
        while (tx_ready !== 1'b1 && k < 50) begin
            wait_n(1);
            k++;
        end
        n_checks++;
        if (tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL push_tx_timeout: tx_ready=%b required 1", tx_ready);
        end
        tx_data  = v;
        tx_valid = 1'b1;
        wait_n(1);
        tx_valid = 1'b0;
    endtask

    // Mode-0 master: sdi set with sck low, sdo sampled just before sck rises.
    task automatic xfer(input logic [7:0] mosi, input int nbits, output logic [7:0] miso);
        miso = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            sdi = mosi[7-i];
            wait_n(6);
            miso = {miso[6:0], sdo};
            sck = 1'b1;
            wait_n(6);
            sck = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; scs = 1'b1; sck = 1'b0; sdi = 1'b0;
        tx_data = 8'h00; tx_valid = 1'b0; rx_ack = 1'b0; err_clr = 1'b0;
        wait_n(3);
        rst = 1'b0;
        wait_n(1);
        n_checks++;
        if ({sdo, sdo_oe, tx_ready, rx_valid, overrun, underrun, busy} !== 7'b0010000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 0010000",
                     {sdo, sdo_oe, tx_ready, rx_valid, overrun, underrun, busy});
        end
        n_checks++;
        if (rx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_rx_data: got %h required 00", rx_data);
        end
        wait_n(6);
    endtask

    task automatic test_basic();
        logic [7:0] m, e;
        push_tx(8'h3C);
        miso_q.push_back(8'h3C);
        rx_q.push_back(8'hA5);
        sel();
        n_checks++;
        if ({busy, sdo_oe} !== 2'b11) begin
            n_fail++;
            $display("FAIL basic_select: busy,sdo_oe=%b required 11", {busy, sdo_oe});
        end
        xfer(8'hA5, 7, m);
        sdi = 1'b1;
        wait_n(6);
        m = {m[6:0], sdo};
        sck = 1'b1;
        wait_n(2);
        n_checks++;
        if (rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_latency_early: rx_valid=%b required 0 two clk after 8th rise", rx_valid);
        end
        wait_n(1);
        n_checks++;
        if (rx_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_latency: rx_valid=%b required 1 three clk after 8th rise", rx_valid);
        end
        wait_n(3);
        sck = 1'b0;
        desel();
        e = miso_q.pop_front();
        n_checks++;
        if (m !== e) begin
            n_fail++;
            $display("FAIL basic_miso: got %h required %h", m, e);
        end
        e = rx_q.pop_front();
        n_checks++;
        if (rx_data !== e || underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_rx: rx_data=%h underrun=%b required %h,0", rx_data, underrun, e);
        end
        ack();
        n_checks++;
        if (rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_ack: rx_valid=%b required 0", rx_valid);
        end
    endtask

    task automatic test_underrun();
        logic [7:0] m, e;
        miso_q.push_back(8'hFF);
        rx_q.push_back(8'h5A);
        sel();
        xfer(8'h5A, 8, m);
        desel();
        e = miso_q.pop_front();
        n_checks++;
        if (m !== e) begin
            n_fail++;
            $display("FAIL underrun_miso: got %h required %h", m, e);
        end
        e = rx_q.pop_front();
        n_checks++;
        if (rx_data !== e || rx_valid !== 1'b1 || underrun !== 1'b1) begin
            n_fail++;
            $display("FAIL underrun_flag: rx_data=%h rx_valid=%b underrun=%b required %h,1,1",
                     rx_data, rx_valid, underrun, e);
        end
        clr_err();
        n_checks++;
        if (underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL underrun_clear: underrun=%b required 0", underrun);
        end
        ack();
    endtask

    task automatic test_back_to_back();
        logic [7:0] m1, m2, e;
        push_tx(8'hC3);
        miso_q.push_back(8'hC3);
        miso_q.push_back(8'h96);
        sel();
        push_tx(8'h96);
        rx_q.push_back(8'h11);
        xfer(8'h11, 8, m1);
        e = rx_q.pop_front();
        n_checks++;
        if (rx_data !== e || rx_valid !== 1'b1 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first: rx_data=%h rx_valid=%b overrun=%b required %h,1,0",
                     rx_data, rx_valid, overrun, e);
        end
        rx_q.push_back(8'h22);
        xfer(8'h22, 8, m2);
        e = rx_q.pop_front();
        n_checks++;
        if (rx_data !== e || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_overrun: rx_data=%h overrun=%b required %h,1", rx_data, overrun, e);
        end
        desel();
        e = miso_q.pop_front();
        n_checks++;
        if (m1 !== e) begin
            n_fail++;
            $display("FAIL b2b_miso0: got %h required %h", m1, e);
        end
        e = miso_q.pop_front();
        n_checks++;
        if (m2 !== e || underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_miso1: got %h underrun=%b required %h,0", m2, underrun, e);
        end
        clr_err();
        ack();
        n_checks++;
        if ({overrun, rx_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_clear: overrun,rx_valid=%b required 00", {overrun, rx_valid});
        end
    endtask

    task automatic test_partial();
        logic [7:0] m, e;
        push_tx(8'hE7);
        sel();
        xfer(8'hB3, 5, m);
        desel();
        n_checks++;
        if ({rx_valid, busy, sdo_oe, sdo} !== 4'b0000) begin
            n_fail++;
            $display("FAIL partial_abort: rx_valid,busy,sdo_oe,sdo=%b required 0000",
                     {rx_valid, busy, sdo_oe, sdo});
        end
        push_tx(8'h42);
        miso_q.push_back(8'h42);
        rx_q.push_back(8'h7E);
        sel();
        xfer(8'h7E, 8, m);
        desel();
        e = miso_q.pop_front();
        n_checks++;
        if (m !== e) begin
            n_fail++;
            $display("FAIL partial_next_miso: got %h required %h", m, e);
        end
        e = rx_q.pop_front();
        n_checks++;
        if (rx_data !== e || rx_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL partial_next_rx: rx_data=%h rx_valid=%b required %h,1", rx_data, rx_valid, e);
        end
        ack();
    endtask

    task automatic test_reset_midframe();
        logic [7:0] m, e;
        push_tx(8'h55);
        sel();
        xfer(8'hCC, 3, m);
        rst = 1'b1;
        wait_n(1);
        rst = 1'b0;
        n_checks++;
        if ({sdo, sdo_oe, tx_ready, rx_valid, overrun, underrun, busy} !== 7'b0010000) begin
            n_fail++;
            $display("FAIL midrst_values: got %b required 0010000",
                     {sdo, sdo_oe, tx_ready, rx_valid, overrun, underrun, busy});
        end
        xfer(8'hFF, 8, m);
        n_checks++;
        if ({rx_valid, busy, sdo_oe} !== 3'b000) begin
            n_fail++;
            $display("FAIL midrst_no_join: rx_valid,busy,sdo_oe=%b required 000", {rx_valid, busy, sdo_oe});
        end
        desel();
        push_tx(8'h5C);
        miso_q.push_back(8'h5C);
        rx_q.push_back(8'h81);
        sel();
        xfer(8'h81, 8, m);
        desel();
        e = miso_q.pop_front();
        n_checks++;
        if (m !== e) begin
            n_fail++;
            $display("FAIL midrst_miso: got %h required %h", m, e);
        end
        e = rx_q.pop_front();
        n_checks++;
        if (rx_data !== e || rx_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_rx: rx_data=%h rx_valid=%b required %h,1", rx_data, rx_valid, e);
        end
    endtask

    // Entered with rx_valid=1 still holding the previous word.
    task automatic test_ack_same_cycle();
        logic [7:0] m, e;
        push_tx(8'h0F);
        miso_q.push_back(8'h0F);
        rx_q.push_back(8'hF0);
        sel();
        xfer(8'hF0, 7, m);
        sdi = 1'b0;
        wait_n(6);
        m = {m[6:0], sdo};
        sck = 1'b1;
        wait_n(2);
        rx_ack = 1'b1;
        wait_n(1);
        rx_ack = 1'b0;
        n_checks++;
        if (rx_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL ackcoll_valid: rx_valid=%b required 1", rx_valid);
        end
        wait_n(3);
        sck = 1'b0;
        desel();
        e = rx_q.pop_front();
        n_checks++;
        if (rx_data !== e || rx_valid !== 1'b1 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL ackcoll_rx: rx_data=%h rx_valid=%b overrun=%b required %h,1,0",
                     rx_data, rx_valid, overrun, e);
        end
        e = miso_q.pop_front();
        n_checks++;
        if (m !== e) begin
            n_fail++;
            $display("FAIL ackcoll_miso: got %h required %h", m, e);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underrun();
        test_back_to_back();
        test_partial();
        test_reset_midframe();
        test_ack_same_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
- SPI responder (slave) that forms the far end of the SoC's SPI master port (spi_master_sck/scs/sdo/sdi).
- Used as a bench/loopback peer and as the on-chip endpoint for test_sck/test_scs/test_sdi/test_sdo.
- Oversamples SCK/SCS/SDI in the system clock domain; mode 0, MSB first, fixed-width frames.
- Parallel side: tx holding buffer with a valid/ready handshake, rx register with valid/ack and sticky error flags.

Parameters:
DATA_W, 8, frame width in bits (4..32)
SYNC_STAGES, 2, synchronizer depth on sck, scs, sdi (>=2)
IDLE_TX, all-ones of DATA_W, word shifted out when tx buffer is empty

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
sck  in  1  SPI clock from master (async)
scs  in  1  chip select, active-low (async)
sdi  in  1  MOSI (async)
sdo  out  1  MISO
sdo_oe  out  1  MISO output enable (1 while selected)
tx_data  in  DATA_W  word to send next
tx_valid  in  1  tx_data valid
tx_ready  out  1  tx buffer empty, can accept a word
rx_data  out  DATA_W  last received word
rx_valid  out  1  rx_data holds an unacknowledged word
rx_ack  in  1  consume rx_data
err_clr  in  1  clear sticky flags
overrun  out  1  sticky: word received while rx_valid=1
underrun  out  1  sticky: IDLE_TX sent because buffer was empty
busy  out  1  frame in progress (state SHIFT)

Behaviour:
- Reset: clk only, synchronous, active-high; rst=1 on a rising clk edge forces reset. Values in reset:
  - sdo=0, sdo_oe=0, tx_ready=1, rx_data=0, rx_valid=0, overrun=0, underrun=0, busy=0.
  - Synchronizers are loaded with the idle pattern: sck=0, scs=1.
  - State goes to WAIT_DESEL.
- Synchronization: each async input passes through SYNC_STAGES flops. Edges are detected by comparing the last sync stage with one extra flop.
- Timing requirement: the SCK high and low phases must each be at least 4 clk cycles.
- FSM states: WAIT_DESEL, IDLE, SHIFT.
  - WAIT_DESEL -> IDLE when synced scs=1. A reset taken mid-frame therefore never joins a transfer already in progress.
  - IDLE -> SHIFT on the scs falling edge:
    - load the tx shift register from the buffer (or IDLE_TX, and set underrun);
    - bitcnt=0, sdo_oe=1, sdo=MSB in the same cycle;
    - tx_ready goes high the next cycle.
  - SHIFT:
    - sck rising: rx_shift <= {rx_shift[DATA_W-2:0], sdi_sync}; bitcnt++.
    - bitcnt reaching DATA_W on a rising edge:
      - rx_data <= completed word, rx_valid=1, bitcnt=0;
      - if rx_valid was already 1 and rx_ack was not asserted that cycle, set overrun (rx_data is overwritten).
    - sck falling edge with bitcnt!=0: shift tx left; sdo = next bit.
    - sck falling edge with bitcnt==0 after a completed word (back-to-back frame under the same CS): reload tx from the buffer/IDLE_TX as at frame start.
    - scs rising edge -> IDLE: partial word discarded, no rx_valid, sdo_oe=0, sdo=0.
- rx latency: rx_valid rises SYNC_STAGES+1 clk cycles after the pin-level 8th sck rising edge (3 cycles at default).
- Tx handshake:
  - tx_ready = buffer empty; tx_valid&&tx_ready loads the buffer.
  - A load and a consume in the same cycle cannot occur, because consume requires the buffer to be full.
  - tx_valid with tx_ready=0 is ignored; the master keeps tx_valid asserted.
- rx_ack: clears rx_valid.
  - rx_ack in the same cycle as a new word completing: new word held, rx_valid stays 1, no overrun.
  - rx_ack with rx_valid=0: no effect.
- err_clr clears overrun and underrun. Set wins over a simultaneous clear.
- Simultaneous scs rise and sck edge in the same cycle: scs wins, and the edge is ignored.
- busy = (state==SHIFT).

Optional Feature:
- Macro: SPI_SLAVE_MODE_SEL_EN.
- With the macro: adds inputs cpol and cpha (1 bit each).
  - They are latched only in IDLE on the scs falling edge.
  - The sample edge is the leading edge for cpha=0 and the trailing edge for cpha=1; the shift edge is the other edge. The leading edge is rising for cpol=0 and falling for cpol=1.
  - For cpha=1, the first shift happens on the first leading edge, and sdo holds the MSB only from that edge.
  - The synchronizer idle value of sck is reset to 0 (cpol is not known at reset).
- Without the macro: fixed mode 0, ports absent.

Decomposition:
- Shared include spi_defs.v holds:
  - SPI_DATA_W default;
  - state encodings SPI_ST_WAIT_DESEL=2'd0, SPI_ST_IDLE=2'd1, SPI_ST_SHIFT=2'd2;
  - mode encodings SPI_MODE0..SPI_MODE3.
- One sub-module, spi_sync_edge: parameterized synchronizer plus rise/fall pulse outputs, with reset value as a parameter.
  - Instantiated for sck and scs; sdi uses its sync output only.

Test Plan:
- Reset, then master sends 8'hA5 with the buffer loaded with 8'h3C -> master reads 8'h3C; rx_data=8'hA5, rx_valid=1 exactly 3 clk after the 8th sck rise; underrun=0.
- Buffer empty, master sends 8'h5A -> master reads 8'hFF; underrun=1; err_clr -> underrun=0.
- Two back-to-back words 8'h11, 8'h22 under one CS with tx 8'hC3 loaded, then 8'h96 loaded after tx_ready rises -> master reads C3, 96; without rx_ack after the first word, overrun=1 and rx_data=8'h22.
- CS deasserted after 5 bits -> rx_valid stays 0, busy falls, sdo_oe=0; the next full frame 8'h7E is received correctly.
- rst pulsed while scs=0 mid-frame -> outputs at reset values; no rx_valid until scs goes high then low; the following 8'h81 frame is received correctly.
- rx_ack in the same cycle a new word 8'hF0 completes -> rx_valid stays 1, rx_data=8'hF0, overrun=0.
